// File: rtl/ssd1306_frame_streamer.sv
// Feeds an SSD1306 byte-level I2C master: addressing-setup commands, then every frame-buffer byte,
// one I2C transaction per byte, with a per-byte timeout.
module ssd1306_frame_streamer #(
  parameter int unsigned COLS    = 128,
  parameter int unsigned PAGES   = 4,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned TIMEOUT = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go_i,
  output logic              fb_rd_en_o,
  output logic [ADDR_W-1:0] fb_addr_o,
  input  logic [7:0]        fb_data_i,
  output logic              i2c_start_o,
  output logic [7:0]        i2c_data_o,
  output logic              i2c_is_cmd_o,
  input  logic              i2c_busy_i,
  input  logic              i2c_done_i,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              timeout_err_o,
  output logic [3:0]        state_debug_o
);

  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TmoW-1:0]   TmoMax   = TmoW'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(PAGES * COLS - 1);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StCmd  = 3'd1,
    StRd   = 3'd2,
    StRdw  = 3'd3,
    StXfer = 3'd4,
    StFin  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        cmd_idx_q, cmd_idx_d;
  logic [ADDR_W-1:0] byte_addr_q, byte_addr_d;
  logic              start_q, start_d;
  logic [7:0]        data_q, data_d;
  logic              is_cmd_q, is_cmd_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              tmo_err_q, tmo_err_d;
  logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [7:0]        hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic [7:0]        cmd_byte;

  always_comb begin
    cmd_byte = 8'h00;
    unique case (cmd_idx_q)
      3'd0:    cmd_byte = 8'h20;
      3'd1:    cmd_byte = 8'h00;
      3'd2:    cmd_byte = 8'h21;
      3'd3:    cmd_byte = 8'h00;
      3'd4:    cmd_byte = 8'(COLS - 1);
      3'd5:    cmd_byte = 8'h22;
      3'd6:    cmd_byte = 8'h00;
      default: cmd_byte = 8'(PAGES - 1);
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cmd_idx_d    = cmd_idx_q;
    byte_addr_d  = byte_addr_q;
    start_d      = start_q;
    data_d       = data_q;
    is_cmd_d     = is_cmd_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    tmo_err_d    = tmo_err_q;
    tmo_cnt_d    = tmo_cnt_q;
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;

    unique case (state_q)
      StIdle: begin
        if (go_i) begin
          busy_d      = 1'b1;
          cmd_idx_d   = 3'd0;
          byte_addr_d = '0;
          tmo_err_d   = 1'b0;
          state_d     = StCmd;
        end
      end
      StCmd: begin
        if (!i2c_busy_i) begin
          data_d    = cmd_byte;
          is_cmd_d  = 1'b1;
          start_d   = 1'b1;
          tmo_cnt_d = '0;
          state_d   = StXfer;
        end
      end
      StRd: begin
        hold_vld_d = 1'b0;
        state_d    = StRdw;
      end
      StRdw: begin
        // fb_data is only valid in the first RDW cycle; keep it if the master is still busy
        if (!hold_vld_q) begin
          hold_d     = fb_data_i;
          hold_vld_d = 1'b1;
        end
        if (!i2c_busy_i) begin
          data_d    = hold_vld_q ? hold_q : fb_data_i;
          is_cmd_d  = 1'b0;
          start_d   = 1'b1;
          tmo_cnt_d = '0;
          state_d   = StXfer;
        end
      end
      StXfer: begin
        if (i2c_busy_i) begin
          start_d = 1'b0;
        end
        if (i2c_done_i) begin
          start_d = 1'b0;
          if (is_cmd_q) begin
            if (cmd_idx_q != 3'd7) begin
              cmd_idx_d = cmd_idx_q + 3'd1;
              state_d   = StCmd;
            end else begin
              state_d = StRd;
            end
          end else if (byte_addr_q != LastAddr) begin
            byte_addr_d = byte_addr_q + 1'b1;
            state_d     = StRd;
          end else begin
            state_d = StFin;
          end
        end else if (tmo_cnt_q == TmoMax) begin
          tmo_err_d = 1'b1;
          start_d   = 1'b0;
          busy_d    = 1'b0;
          state_d   = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      StFin: begin
        frame_done_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cmd_idx_q    <= 3'd0;
      byte_addr_q  <= '0;
      start_q      <= 1'b0;
      data_q       <= 8'h00;
      is_cmd_q     <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      tmo_err_q    <= 1'b0;
      tmo_cnt_q    <= '0;
      hold_q       <= 8'h00;
      hold_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_idx_q    <= cmd_idx_d;
      byte_addr_q  <= byte_addr_d;
      start_q      <= start_d;
      data_q       <= data_d;
      is_cmd_q     <= is_cmd_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      tmo_err_q    <= tmo_err_d;
      tmo_cnt_q    <= tmo_cnt_d;
      hold_q       <= hold_d;
      hold_vld_q   <= hold_vld_d;
    end
  end

  assign fb_rd_en_o    = (state_q == StRd);
  assign fb_addr_o     = (state_q == StRd) ? byte_addr_q : '0;
  assign i2c_start_o   = start_q;
  assign i2c_data_o    = data_q;
  assign i2c_is_cmd_o  = is_cmd_q;
  assign busy_o        = busy_q;
  assign frame_done_o  = frame_done_q;
  assign timeout_err_o = tmo_err_q;
  assign state_debug_o = {1'b0, state_q};

endmodule

// File: tb/tb_ssd1306_frame_streamer.sv
// Directed bench for ssd1306_frame_streamer: I2C master model, frame-buffer RAM model, and
// per-scenario tasks with hand-computed expectations.
module tb_ssd1306_frame_streamer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       go = 1'b0;
  logic       fb_rd_en;
  logic [8:0] fb_addr;
  logic [7:0] fb_data = 8'hEE;
  logic       i2c_start;
  logic [7:0] i2c_data;
  logic       i2c_is_cmd;
  logic       i2c_busy = 1'b0;
  logic       i2c_done = 1'b0;
  logic       busy;
  logic       frame_done;
  logic       timeout_err;
  logic [3:0] state_debug;

  int n_tests = 0;
  int n_fail  = 0;

  ssd1306_frame_streamer #(
    .COLS   (128),
    .PAGES  (4),
    .ADDR_W (9),
    .TIMEOUT(1000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .go_i         (go),
    .fb_rd_en_o   (fb_rd_en),
    .fb_addr_o    (fb_addr),
    .fb_data_i    (fb_data),
    .i2c_start_o  (i2c_start),
    .i2c_data_o   (i2c_data),
    .i2c_is_cmd_o (i2c_is_cmd),
    .i2c_busy_i   (i2c_busy),
    .i2c_done_i   (i2c_done),
    .busy_o       (busy),
    .frame_done_o (frame_done),
    .timeout_err_o(timeout_err),
    .state_debug_o(state_debug)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM: mem[a] = a[7:0]; junk outside the valid cycle
  always @(posedge clk) begin
    if (fb_rd_en) fb_data <= fb_addr[7:0];
    else          fb_data <= 8'hEE;
  end

  // Master model (negedge driven)
  int   start_dly = 1, done_dly = 3;
  int   hang_idx = -1, sp_idx = -1, sp_dly = 0, st_idx = -1, st_dly = 0;
  bit   m_clear = 0;
  int   m_st = 0, m_cnt = 0, cur = 0;
  logic [7:0] log_data [0:1023];
  logic       log_cmd  [0:1023];
  int   log_t [0:1023];
  int   log_dn[0:1023];
  int   log_shi[0:1023];
  int   tx_cnt = 0, fd_cnt = 0, fd_cyc = 0, err_cyc = 0;
  logic fd_busy = 1'b0;
  bit   err_seen = 0, data_chg = 0;

  initial begin
    forever begin
      @(negedge clk);
      i2c_done = 1'b0;
      if (!rst_n || m_clear) begin
        m_st = 0;
        i2c_busy = 1'b0;
        m_clear = 0;
      end else begin
        if (frame_done) begin
          fd_cnt++;
          fd_cyc = cyc;
          fd_busy = busy;
        end
        if (timeout_err && !err_seen) begin
          err_seen = 1;
          err_cyc = cyc;
        end
        if (m_st != 0 && i2c_start) log_shi[cur]++;
        if (m_st != 0 && (i2c_data !== log_data[cur] || i2c_is_cmd !== log_cmd[cur])) data_chg = 1;
        case (m_st)
          0: if (i2c_start && tx_cnt < 1024) begin
            cur = tx_cnt;
            log_data[cur] = i2c_data;
            log_cmd[cur] = i2c_is_cmd;
            log_t[cur] = cyc;
            log_shi[cur] = 1;
            tx_cnt++;
            m_cnt = (cur == st_idx) ? st_dly : start_dly;
            m_st = 1;
          end
          1: begin
            m_cnt--;
            if (m_cnt <= 0) begin
              i2c_busy = 1'b1;
              m_cnt = (cur == sp_idx) ? sp_dly : done_dly;
              m_st = (cur == hang_idx) ? 3 : 2;
            end
          end
          2: begin
            m_cnt--;
            if (m_cnt <= 0) begin
              i2c_done = 1'b1;
              i2c_busy = 1'b0;
              log_dn[cur] = cyc;
              m_st = 0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic [7:0] exp_cmd [8] = '{8'h20, 8'h00, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h03};

  task automatic clear_logs();
    @(posedge clk); #2;
    tx_cnt = 0;
    fd_cnt = 0;
    err_seen = 0;
    data_chg = 0;
  endtask

  task automatic pulse_go();
    @(posedge clk); #2;
    go = 1'b1;
    @(posedge clk); #2;
    go = 1'b0;
  endtask

  task automatic wait_frame(input int budget, output bit ok);
    int f0;
    f0 = fd_cnt;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (fd_cnt > f0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int  hi;
    bit  seen;
    logic [27:0] got;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    got = {i2c_start, i2c_data, i2c_is_cmd, fb_rd_en, fb_addr, busy, frame_done, timeout_err,
           state_debug};
    n_tests++;
    if (got !== {1'b0, 8'h00, 1'b1, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_values: got %h want %h", got,
               {1'b0, 8'h00, 1'b1, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 4'd0});
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    clear_logs();
    pulse_go();
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (state_debug == 4'd4 && i2c_start) begin
        seen = 1;
        break;
      end
      @(posedge clk); #2;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL reset_reach_xfer: got no XFER want XFER within 200 cycles");
    end
    rst_n = 1'b0;
    #1;
    got = {i2c_start, i2c_data, i2c_is_cmd, fb_rd_en, fb_addr, busy, frame_done, timeout_err,
           state_debug};
    n_tests++;
    if (got !== {1'b0, 8'h00, 1'b1, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_async_mid_xfer: got %h want %h", got,
               {1'b0, 8'h00, 1'b1, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 4'd0});
    end
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #2;
      if (i2c_start !== 1'b0) hi++;
    end
    n_tests++;
    if (hi != 0) begin
      n_fail++;
      $display("FAIL reset_no_restart: got %0d start cycles want 0", hi);
    end
  endtask

  task automatic test_full_frame();
    bit ok;
    logic [7:0] ed;
    logic ec;
    clear_logs();
    pulse_go();
    n_tests++;
    if (busy !== 1'b1 || i2c_start !== 1'b0) begin
      n_fail++;
      $display("FAIL go_to_busy: got busy=%b start=%b want busy=1 start=0", busy, i2c_start);
    end
    @(posedge clk); #2;
    n_tests++;
    if (i2c_start !== 1'b1) begin
      n_fail++;
      $display("FAIL first_start: got %b want 1", i2c_start);
    end
    wait_frame(10000, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL full_frame_timeout: got no frame_done want frame_done within 10000 cycles");
    end
    repeat (20) @(posedge clk);
    #2;
    n_tests++;
    if (tx_cnt != 520) begin
      n_fail++;
      $display("FAIL full_tx_count: got %0d want 520", tx_cnt);
    end
    for (int i = 0; i < 520; i++) begin
      ed = (i < 8) ? exp_cmd[i] : 8'(i - 8);
      ec = (i < 8) ? 1'b1 : 1'b0;
      n_tests++;
      if (log_data[i] !== ed || log_cmd[i] !== ec) begin
        n_fail++;
        $display("FAIL full_byte[%0d]: got %h/cmd=%b want %h/cmd=%b", i, log_data[i], log_cmd[i],
                 ed, ec);
      end
    end
    n_tests++;
    if (fd_cnt != 1 || err_seen || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL full_done_err: got fd=%0d err=%b want fd=1 err=0", fd_cnt, timeout_err);
    end
    n_tests++;
    if (fd_cyc - log_dn[519] != 2 || fd_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_done_timing: got %0d edges busy=%b want 2 edges busy=0",
               fd_cyc - log_dn[519], fd_busy);
    end
    n_tests++;
    if (log_t[1] - log_dn[0] != 2) begin
      n_fail++;
      $display("FAIL cmd_gap: got %0d want 2", log_t[1] - log_dn[0]);
    end
    n_tests++;
    if (log_t[8] - log_dn[7] != 3 || log_t[9] - log_dn[8] != 3) begin
      n_fail++;
      $display("FAIL data_gap: got %0d,%0d want 3,3", log_t[8] - log_dn[7], log_t[9] - log_dn[8]);
    end
  endtask

  task automatic test_start_handshake();
    bit ok;
    st_idx = 9;
    st_dly = 150;
    clear_logs();
    pulse_go();
    wait_frame(10000, ok);
    st_idx = -1;
    n_tests++;
    if (!ok || tx_cnt != 520) begin
      n_fail++;
      $display("FAIL hs_frame: got done=%b tx=%0d want done=1 tx=520", ok, tx_cnt);
    end
    n_tests++;
    if (log_shi[9] != 151) begin
      n_fail++;
      $display("FAIL hs_start_len: got %0d want 151", log_shi[9]);
    end
    n_tests++;
    if (data_chg || log_data[9] !== 8'h01) begin
      n_fail++;
      $display("FAIL hs_data_stable: got chg=%b data=%h want chg=0 data=01", data_chg,
               log_data[9]);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    hang_idx = 13;
    clear_logs();
    pulse_go();
    ok = 0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #2;
      if (err_seen) begin
        ok = 1;
        break;
      end
    end
    repeat (5) @(posedge clk);
    #2;
    n_tests++;
    if (!ok || err_cyc - log_t[13] != 1000) begin
      n_fail++;
      $display("FAIL tmo_timing: got seen=%b edges=%0d want seen=1 edges=1000", ok,
               err_cyc - log_t[13]);
    end
    n_tests++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || state_debug !== 4'd0 || i2c_start !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_outputs: got err=%b busy=%b st=%0d start=%b want 1 0 0 0", timeout_err,
               busy, state_debug, i2c_start);
    end
    n_tests++;
    if (fd_cnt != 0 || tx_cnt != 14) begin
      n_fail++;
      $display("FAIL tmo_abandon: got fd=%0d tx=%0d want fd=0 tx=14", fd_cnt, tx_cnt);
    end
    hang_idx = -1;
    m_clear = 1;
    repeat (2) @(posedge clk);
    clear_logs();
    pulse_go();
    n_tests++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_clear_on_go: got %b want 0", timeout_err);
    end
    wait_frame(10000, ok);
    n_tests++;
    if (!ok || fd_cnt != 1 || tx_cnt != 520) begin
      n_fail++;
      $display("FAIL tmo_recover: got fd=%0d tx=%0d want fd=1 tx=520", fd_cnt, tx_cnt);
    end
  endtask

  task automatic test_ignored_go();
    bit ok;
    clear_logs();
    pulse_go();
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #2;
      if (tx_cnt >= 108) begin
        ok = 1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL ig_reach_byte100: got tx=%0d want 108", tx_cnt);
    end
    pulse_go();
    wait_frame(10000, ok);
    repeat (50) @(posedge clk);
    #2;
    n_tests++;
    if (tx_cnt != 520 || fd_cnt != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ig_single_frame: got tx=%0d fd=%0d busy=%b want 520 1 0", tx_cnt, fd_cnt,
               busy);
    end
  endtask

  task automatic test_done_at_timeout();
    bit ok;
    sp_idx = 10;
    sp_dly = 998;
    clear_logs();
    pulse_go();
    wait_frame(10000, ok);
    sp_idx = -1;
    n_tests++;
    if (err_seen || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_no_err: got err=%b want 0", timeout_err);
    end
    n_tests++;
    if (!ok || tx_cnt != 520 || log_data[11] !== 8'h03) begin
      n_fail++;
      $display("FAIL sim_continue: got tx=%0d byte11=%h want tx=520 byte11=03", tx_cnt,
               log_data[11]);
    end
    n_tests++;
    if (log_t[11] - log_dn[10] != 3) begin
      n_fail++;
      $display("FAIL sim_next_start: got %0d want 3", log_t[11] - log_dn[10]);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_start_handshake();
    test_timeout();
    test_ignored_go();
    test_done_at_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
